// File: rtl/hdmi_line_fetch.sv
// Line-prefetch controller for the DRAM-backed HDMI path: per-line burst requests, pixel coordinates, underrun flag.
// Optional statistics counters are enabled by defining HDMI_LINE_FETCH_STATS_EN.
`timescale 1ns/1ps

module hdmi_line_fetch #(
  parameter int          X_SIZE      = 1280,
  parameter int          Y_SIZE      = 720,
  parameter int          BPP_BYTES   = 4,
  parameter int          LINE_STRIDE = X_SIZE * BPP_BYTES,
  parameter logic [31:0] BASE_ADDR0  = 32'h0000_0000,
  parameter logic [31:0] BASE_ADDR1  = 32'h0040_0000,
  parameter int          FIFO_AW     = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               framestart,
  input  logic               prefetch_line,
  input  logic               de,
  input  logic               buf_sel,
  output logic               kick,
  input  logic               busy,
  output logic [31:0]        read_addr,
  output logic [31:0]        read_num,
  input  logic [FIFO_AW-1:0] fifo_cnt,
  output logic               fifo_rd,
  output logic               img_de,
  output logic [11:0]        x,
  output logic [11:0]        y,
  output logic               underrun,
  input  logic               underrun_clr
`ifdef HDMI_LINE_FETCH_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        underrun_cnt
`endif
);

  localparam logic [11:0] XS     = 12'(X_SIZE);
  localparam logic [11:0] YS     = 12'(Y_SIZE);
  localparam logic [15:0] YL     = 16'(Y_SIZE);
  localparam logic [16:0] YL17   = 17'(Y_SIZE);
  localparam logic [31:0] STRIDE = 32'(LINE_STRIDE);
  localparam logic [31:0] NUM    = 32'(X_SIZE * BPP_BYTES);

  typedef enum logic [1:0] {IDLE, KICK, RUN} state_e;

  state_e      state_q;
  logic        kick_q;
  logic [31:0] read_addr_q;
  logic        de_q;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        underrun_q, underrun_d;
  logic [15:0] fetch_line_q, fetch_line_d;
  logic [1:0]  pend_q, pend_d;
  logic [31:0] base_q, base_d;
  logic        stale_q, stale_d;
  logic        done;
  logic        inflight;
  logic        advance;
  logic        accept;
  logic        empty_read;
  logic [31:0] next_addr;

  assign kick       = kick_q;
  assign read_addr  = read_addr_q;
  assign read_num   = NUM;
  assign x          = x_q;
  assign y          = y_q;
  assign underrun   = underrun_q;
  assign img_de     = de && (x_q < XS) && (y_q < YS);
  assign fifo_rd    = img_de;
  assign empty_read = img_de && (fifo_cnt == '0);
  assign next_addr  = base_q + 32'(fetch_line_q) * STRIDE;

  // Falling edge of de ends a line; framestart overrides everything.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (framestart) begin
      x_d = '0;
      y_d = '0;
    end else if (de_q && !de) begin
      x_d = '0;
      y_d = (y_q < YS) ? y_q + 12'd1 : y_q;
    end else if (de) begin
      x_d = (x_q < XS) ? x_q + 12'd1 : x_q;
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (empty_read)
      underrun_d = 1'b1;
    else if (underrun_clr)
      underrun_d = 1'b0;
  end

  // A burst interrupted by framestart is "stale": it must finish, but it no longer belongs to the frame.
  always_comb begin
    pend_d       = pend_q;
    fetch_line_d = fetch_line_q;
    base_d       = base_q;
    stale_d      = stale_q;
    done         = (state_q == RUN) && !busy;
    inflight     = (state_q == KICK) || ((state_q == RUN) && busy);
    advance      = 1'b0;
    accept       = 1'b0;
    if (framestart) begin
      base_d       = buf_sel ? BASE_ADDR1 : BASE_ADDR0;
      fetch_line_d = '0;
      pend_d       = 2'd1;
      stale_d      = inflight;
    end else begin
      if (done)
        stale_d = 1'b0;
      advance = done && !stale_q;
      accept  = prefetch_line && (pend_q != 2'd3) &&
                (({1'b0, fetch_line_q} + {15'b0, pend_q}) < YL17);
      if (advance)
        fetch_line_d = fetch_line_q + 16'd1;
      if (accept && !advance)
        pend_d = pend_q + 2'd1;
      else if (advance && !accept)
        pend_d = pend_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      underrun_q   <= 1'b0;
      fetch_line_q <= '0;
      pend_q       <= '0;
      base_q       <= BASE_ADDR0;
      stale_q      <= 1'b0;
    end else begin
      de_q         <= de;
      x_q          <= x_d;
      y_q          <= y_d;
      underrun_q   <= underrun_d;
      fetch_line_q <= fetch_line_d;
      pend_q       <= pend_d;
      base_q       <= base_d;
      stale_q      <= stale_d;
    end
  end

  // A new request is held off during framestart so it always uses the fresh base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      kick_q      <= 1'b0;
      read_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!framestart && (pend_q != 2'd0) && (fetch_line_q < YL)) begin
            state_q     <= KICK;
            kick_q      <= 1'b1;
            read_addr_q <= next_addr;
          end
        end
        KICK: begin
          if (busy) begin
            state_q <= RUN;
            kick_q  <= 1'b0;
          end
        end
        RUN: begin
          if (!busy)
            state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          kick_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HDMI_LINE_FETCH_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] underrun_cnt_q;

  assign frame_cnt    = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      if (framestart)
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if (underrun_clr)
        underrun_cnt_q <= empty_read ? 16'd1 : 16'd0;
      else if (empty_read && (underrun_cnt_q != 16'hFFFF))
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_line_fetch.sv
// Scoreboard bench for hdmi_line_fetch: expected burst addresses queued by stimulus, checked by a kick monitor.
`timescale 1ns/1ps

module tb_hdmi_line_fetch;

  localparam int          XS = 1280;
  localparam int          YS = 4;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        framestart;
  logic        prefetch_line;
  logic        de;
  logic        buf_sel;
  logic        kick;
  logic        busy;
  logic [31:0] read_addr;
  logic [31:0] read_num;
  logic [11:0] fifo_cnt;
  logic        fifo_rd;
  logic        img_de;
  logic [11:0] x;
  logic [11:0] y;
  logic        underrun;
  logic        underrun_clr;

  logic        engBusy;
  logic        holdBusy;
  logic [31:0] expQ[$];
  int          kicksSeen = 0;
  int          testsRun = 0;
  int          testsFailed = 0;

  assign busy = engBusy | holdBusy;

  always #5 clk = ~clk;

  hdmi_line_fetch #(
    .X_SIZE(XS),
    .Y_SIZE(YS),
    .BPP_BYTES(4),
    .LINE_STRIDE(5120),
    .BASE_ADDR0(B0),
    .BASE_ADDR1(B1),
    .FIFO_AW(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .framestart(framestart),
    .prefetch_line(prefetch_line),
    .de(de),
    .buf_sel(buf_sel),
    .kick(kick),
    .busy(busy),
    .read_addr(read_addr),
    .read_num(read_num),
    .fifo_cnt(fifo_cnt),
    .fifo_rd(fifo_rd),
    .img_de(img_de),
    .x(x),
    .y(y),
    .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic pf, input logic sel);
    @(negedge clk);
    framestart    = fs;
    prefetch_line = pf;
    buf_sel       = sel;
    @(negedge clk);
    framestart    = 1'b0;
    prefetch_line = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // DRAM engine stand-in: answers each kick with a three-cycle busy pulse.
  initial begin
    engBusy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (kick === 1'b1 && !engBusy) begin
        engBusy = 1'b1;
        repeat (3) @(posedge clk);
        #2 engBusy = 1'b0;
      end
    end
  end

  initial begin
    logic        kickPrev;
    logic [31:0] e;
    kickPrev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (kick === 1'b1 && !kickPrev) begin
        kicksSeen++;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_kick: got read_addr 0x%0h, expected no kick", read_addr);
        end else begin
          e = expQ.pop_front();
          checkOutput("kick_read_addr", read_addr, e);
          checkOutput("kick_read_num", read_num, 32'd5120);
        end
      end
      kickPrev = (kick === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    framestart    = 1'b0;
    prefetch_line = 1'b0;
    de            = 1'b0;
    buf_sel       = 1'b0;
    holdBusy      = 1'b0;
    fifo_cnt      = 12'd100;
    underrun_clr  = 1'b0;
    waitCycles(3);
    checkOutput("rst_kick", 32'(kick), 32'd0);
    checkOutput("rst_read_addr", read_addr, 32'd0);
    checkOutput("rst_read_num", read_num, 32'd5120);
    checkOutput("rst_x", 32'(x), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_img_de", 32'(img_de), 32'd0);
    rst_n = 1'b1;
    waitCycles(2);

    // Frame on buffer 1: line 0 fetched automatically.
    expQ.push_back(32'h0040_0000);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCycles(12);
    checkOutput("kicks_frame_start", 32'(kicksSeen), 32'd1);

    // Three prefetches queued while the engine is held busy.
    holdBusy = 1'b1;
    expQ.push_back(32'h0040_1400);
    expQ.push_back(32'h0040_2800);
    expQ.push_back(32'h0040_3C00);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(4);
    holdBusy = 1'b0;
    waitCycles(40);
    checkOutput("kicks_after_prefetch", 32'(kicksSeen), 32'd4);

    // Frame exhausted: further prefetches must be ignored.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(10);
    checkOutput("kicks_capped_y_size", 32'(kicksSeen), 32'd4);

    // framestart while a burst is in flight.
    holdBusy = 1'b1;
    expQ.push_back(32'h0040_0000);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCycles(4);
    checkOutput("kicks_before_restart", 32'(kicksSeen), 32'd5);
    expQ.push_back(32'h0000_0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(3);
    holdBusy = 1'b0;
    waitCycles(20);
    checkOutput("kicks_after_restart", 32'(kicksSeen), 32'd6);
    expQ.push_back(32'h0000_1400);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(15);
    checkOutput("kicks_line1_new_base", 32'(kicksSeen), 32'd7);

    // Underrun: pixel read with empty FIFO, then clear, then set-beats-clear.
    @(negedge clk);
    de = 1'b1;
    fifo_cnt = 12'd0;
    #1;
    checkOutput("img_de_active", 32'(img_de), 32'd1);
    checkOutput("fifo_rd_active", 32'(fifo_rd), 32'd1);
    checkOutput("underrun_before", 32'(underrun), 32'd0);
    @(negedge clk);
    de = 1'b0;
    fifo_cnt = 12'd100;
    checkOutput("underrun_set", 32'(underrun), 32'd1);
    waitCycles(3);
    checkOutput("underrun_sticky", 32'(underrun), 32'd1);
    @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checkOutput("underrun_cleared", 32'(underrun), 32'd0);
    @(negedge clk);
    de = 1'b1;
    fifo_cnt = 12'd0;
    underrun_clr = 1'b1;
    @(negedge clk);
    de = 1'b0;
    fifo_cnt = 12'd100;
    underrun_clr = 1'b0;
    checkOutput("underrun_set_wins", 32'(underrun), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;

    // Long active line: x saturates at X_SIZE, then de falling edge advances y.
    expQ.push_back(32'h0000_0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("fs_x", 32'(x), 32'd0);
    checkOutput("fs_y", 32'(y), 32'd0);
    @(negedge clk);
    de = 1'b1;
    for (int i = 1; i <= 1300; i++) begin
      @(negedge clk);
      if (i == 1279) begin
        checkOutput("x_1279", 32'(x), 32'd1279);
        checkOutput("img_de_last_pixel", 32'(img_de), 32'd1);
      end
      if (i == 1280) begin
        checkOutput("x_1280", 32'(x), 32'd1280);
        checkOutput("img_de_past_line", 32'(img_de), 32'd0);
      end
    end
    checkOutput("x_saturated", 32'(x), 32'd1280);
    de = 1'b0;
    @(negedge clk);
    checkOutput("x_line_end", 32'(x), 32'd0);
    checkOutput("y_line_end", 32'(y), 32'd1);
    checkOutput("underrun_none", 32'(underrun), 32'd0);

    // y saturates at Y_SIZE and blanks the image.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      de = 1'b1;
      @(negedge clk);
      de = 1'b0;
      @(negedge clk);
    end
    checkOutput("y_saturated", 32'(y), 32'd4);
    de = 1'b1;
    #1;
    checkOutput("img_de_below_frame", 32'(img_de), 32'd0);
    @(negedge clk);
    de = 1'b0;

    waitCycles(10);
    checkOutput("kicks_total", 32'(kicksSeen), 32'd8);
    checkOutput("expected_kicks_left", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
